// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, bit-timing helper and default parameters.
package uart_pkg;

  localparam int DEF_CLOCK_FREQ = 50_000_000;
  localparam int DEF_BAUD_RATE  = 115_200;
  localparam int DEF_DATA_BITS  = 8;

  typedef enum logic [2:0] {
    RX_IDLE    = 3'd0,
    RX_START   = 3'd1,
    RX_DATA    = 3'd2,
    RX_STOP    = 3'd3,
    RX_CLEANUP = 3'd4
  } uart_rx_state_t;

  function automatic int clks_per_bit(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Received-byte interface between the UART receiver (master) and its byte consumer (slave).
interface uart_rx_if
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DEF_DATA_BITS
) ();

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_busy;
  logic                 rx_frame_err;

  modport master (output rx_data, output rx_valid, output rx_busy, output rx_frame_err);
  modport slave  (input  rx_data, input  rx_valid, input  rx_busy, input  rx_frame_err);

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input, with a configurable reset value.
module sync_2ff #(
  parameter bit RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled start-bit validation, mid-bit data sampling, stop-bit check.
//
// state   | meaning
// IDLE    | line idle, waiting for rx_s low
// START   | wait half a bit, confirm start bit still low
// DATA    | sample one data bit per bit period, LSB first
// STOP    | sample stop bit, emit valid or framing error
// CLEANUP | hold until line returns high (absorbs breaks)
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = DEF_CLOCK_FREQ,
  parameter int BAUD_RATE  = DEF_BAUD_RATE,
  parameter int DATA_BITS  = DEF_DATA_BITS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_serial,
  uart_rx_if.master  rx_if
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLOCK_FREQ, BAUD_RATE);
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W        = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  uart_rx_state_t       state;
  uart_rx_state_t       state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 rx_s;
  logic                 bit_tick;
  logic                 half_tick;
  logic                 valid_nxt;
  logic                 err_nxt;
  logic                 busy_c;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx_serial),
    .q     (rx_s)
  );

  assign bit_tick  = (cnt == BIT_LAST);
  assign half_tick = (cnt == HALF_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RX_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RX_IDLE:    if (!rx_s) state_nxt = RX_START;
      RX_START:   if (half_tick) state_nxt = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:    if (bit_tick && (bit_idx == IDX_LAST)) state_nxt = RX_STOP;
      RX_STOP:    if (bit_tick) state_nxt = RX_CLEANUP;
      RX_CLEANUP: if (rx_s) state_nxt = RX_IDLE;
      default:    state_nxt = RX_IDLE;
    endcase
  end

  always_comb begin
    busy_c    = (state != RX_IDLE);
    valid_nxt = 1'b0;
    err_nxt   = 1'b0;
    if (state == RX_STOP && bit_tick) begin
      valid_nxt = rx_s;
      err_nxt   = !rx_s;
    end
  end

  // Counter restarts on every state change and at each data-bit boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
    end else begin
      if (state_nxt != state || (state == RX_DATA && bit_tick) ||
          state == RX_IDLE || state == RX_CLEANUP) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end

      if (state == RX_START) begin
        bit_idx <= '0;
      end else if (state == RX_DATA && bit_tick) begin
        shift_reg[bit_idx] <= rx_s;
        bit_idx            <= bit_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_if.rx_data      <= '0;
      rx_if.rx_valid     <= 1'b0;
      rx_if.rx_frame_err <= 1'b0;
    end else begin
      rx_if.rx_valid     <= valid_nxt;
      rx_if.rx_frame_err <= err_nxt;
      if (valid_nxt) begin
        rx_if.rx_data <= shift_reg;
      end
    end
  end

  assign rx_if.rx_busy = busy_c;

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver, the counterpart of the existing uart_tx in the FPGA-01 UART path. It oversamples the asynchronous serial line, detects and validates the start bit, and samples data bits LSB first at mid-bit. It checks the stop bit and presents each received byte on a one-cycle valid strobe, with a framing-error flag. It sits between the board RX pin and the downstream byte consumer (FIFO or command parser).

Parameters:
CLOCK_FREQ, 50_000_000, system clock frequency in Hz
BAUD_RATE, 115200, serial bit rate
DATA_BITS, 8, data bits per frame (5..9), LSB first, no parity, 1 stop bit

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  asynchronous active-low reset
rx_serial  input  1  asynchronous serial line; idle high
rx_data  output  DATA_BITS  last received byte; held stable until next valid frame
rx_valid  output  1  one-cycle pulse when rx_data updates (good stop bit)
rx_busy  output  1  high from start-bit detection until return to IDLE
rx_frame_err  output  1  one-cycle pulse when the stop bit samples 0

Behaviour:
- Reset is asynchronous and active-low on rst_n, one clock clk. On reset: rx_data=0, rx_valid=0, rx_busy=0, rx_frame_err=0, state=IDLE, synchroniser flops=1.
- rx_serial passes through a 2-flop synchroniser reset to 1. All decisions use the synchronised value (rx_s).
- CLKS_PER_BIT = CLOCK_FREQ/BAUD_RATE (integer divide; 434 at the defaults). HALF_BIT = CLKS_PER_BIT/2.
- Baud counter width is $clog2(CLKS_PER_BIT). The counter resets to 0 on every state change.
- FSM states: IDLE, START, DATA, STOP, CLEANUP.
  - IDLE: rx_busy=0. When rx_s==0, go to START.
  - START: count HALF_BIT-1 cycles, then sample.
    - rx_s==0: go to DATA with bit index 0.
    - rx_s==1: glitch; return to IDLE with no output pulses.
  - DATA: every CLKS_PER_BIT cycles, shift rx_s into bit[index], LSB first. After bit DATA_BITS-1, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample.
    - rx_s==1: rx_data<=shift reg, rx_valid=1 for one cycle.
    - rx_s==0: rx_frame_err=1 for one cycle; rx_data unchanged.
    - Either way, go to CLEANUP.
  - CLEANUP: one cycle. Then go to IDLE only if rx_s==1. If the line stays low (break), remain in CLEANUP and do not retrigger. This prevents a break from producing repeated frames.
- rx_busy=1 in START, DATA, STOP and CLEANUP.
- rx_valid and rx_frame_err are mutually exclusive, registered, and never asserted in consecutive cycles.
- Back-to-back frames: a start bit arriving immediately after a good stop bit is detected within HALF_BIT of its edge. Frames at full baud rate with one stop bit are received without loss.
- Latency: rx_valid rises ~(DATA_BITS+1.5)*CLKS_PER_BIT + 3 cycles after the start-bit falling edge on the pin (2 synchroniser + 1 register).
- Reset asserted mid-frame: everything returns to reset values immediately with no pulse. After release, a line that is already low is treated as a start bit.

Decomposition:
- Package uart_pkg: state enum typedef (uart_rx_state_t, shared style with the tx FSM), a function computing clks_per_bit(CLOCK_FREQ, BAUD_RATE), and common defaults (CLOCK_FREQ, BAUD_RATE, DATA_BITS).
- One natural sub-module: sync_2ff (parameterised reset value) for rx_serial. The FSM and counters stay in uart_rx.

Test Plan:
- Reset, line idle, then drive frame 0xA5 at 8680 ns/bit -> one rx_valid pulse with rx_data=0xA5, rx_frame_err=0, rx_busy low afterwards.
- Frames 0x00, 0x55, 0xAA, 0xFF, 0x42 back-to-back with 1 stop bit -> five rx_valid pulses in order, correct data, no gaps lost.
- 2000 ns low glitch on idle line -> rx_busy pulses briefly, no rx_valid, no rx_frame_err, returns to IDLE.
- Frame 0x3C with stop bit forced 0, line then returned high -> rx_frame_err pulse, no rx_valid, rx_data keeps previous 0xA5. The next good frame 0x81 is received correctly.
- Line held low for 20 bit times (break) -> exactly one rx_frame_err and no further activity until the line goes high. The next frame 0x7E is received.
- Assert rst_n mid data bit 3 of 0xC3, release, send 0x96 -> no output for the aborted frame, rx_data=0x96 on valid. Also loop back uart_tx->uart_rx with 3 random bytes to confirm they match.
